writeback_pipe: RTL

WRITEBACK_PIPE -- requirements
Module: writeback_pipe

---
 rtl/writeback_pipe_if.sv | 67 ++++++
 rtl/writeback_pipe.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/writeback_pipe_if.sv
// Bundle of issue, result, register-table and forwarding signals for the
// even/odd writeback pipes. The master side drives issues, results and
// forwarding lookups; the slave side is the writeback block itself.
interface writeback_pipe_if;
  logic         even_issue_valid;
  logic         odd_issue_valid;
  logic         even_issue_ready;
  logic         odd_issue_ready;
  logic [6:0]   even_issue_addr;
  logic [6:0]   odd_issue_addr;
  logic         even_issue_we;
  logic         odd_issue_we;
  logic [2:0]   even_issue_lat;
  logic [2:0]   odd_issue_lat;
  logic         even_res_valid;
  logic         odd_res_valid;
  logic [127:0] even_res_data;
  logic [127:0] odd_res_data;
  logic [6:0]   rt_addr_even;
  logic [6:0]   rt_addr_odd;
  logic [127:0] rt_even;
  logic [127:0] rt_odd;
  logic         reg_write_even;
  logic         reg_write_odd;
  logic [6:0]   fwd_addr_a;
  logic [6:0]   fwd_addr_b;
  logic [127:0] fwd_data_a;
  logic [127:0] fwd_data_b;
  logic         fwd_hit_a;
  logic         fwd_hit_b;
  logic         wb_err_even;
  logic         wb_err_odd;

  modport master (
    output even_issue_valid, odd_issue_valid,
    output even_issue_addr, odd_issue_addr,
    output even_issue_we, odd_issue_we,
    output even_issue_lat, odd_issue_lat,
    output even_res_valid, odd_res_valid,
    output even_res_data, odd_res_data,
    output fwd_addr_a, fwd_addr_b,
    input  even_issue_ready, odd_issue_ready,
    input  rt_addr_even, rt_addr_odd,
    input  rt_even, rt_odd,
    input  reg_write_even, reg_write_odd,
    input  fwd_data_a, fwd_data_b,
    input  fwd_hit_a, fwd_hit_b,
    input  wb_err_even, wb_err_odd
  );

  modport slave (
    input  even_issue_valid, odd_issue_valid,
    input  even_issue_addr, odd_issue_addr,
    input  even_issue_we, odd_issue_we,
    input  even_issue_lat, odd_issue_lat,
    input  even_res_valid, odd_res_valid,
    input  even_res_data, odd_res_data,
    input  fwd_addr_a, fwd_addr_b,
    output even_issue_ready, odd_issue_ready,
    output rt_addr_even, rt_addr_odd,
    output rt_even, rt_odd,
    output reg_write_even, reg_write_odd,
    output fwd_data_a, fwd_data_b,
    output fwd_hit_a, fwd_hit_b,
    output wb_err_even, wb_err_odd
  );
endinterface

// File: rtl/writeback_pipe.sv
// Dual (even/odd) writeback pipe. Each pipe is a 7-stage shift register of
// in-flight instructions; the execution result is captured when an entry
// reaches the stage equal to its latency, and the register-table write is
// issued from a registered writeback slot after stage 7. A combinational
// forwarding network exposes the youngest in-flight value for two lookups.
// Index 0 of every internal array is the even pipe, index 1 the odd pipe.
module writeback_pipe (
  input logic             clk,
  input logic             reset,
  writeback_pipe_if.slave bus
);

  logic         issue_valid [2];
  logic         issue_we    [2];
  logic [6:0]   issue_addr  [2];
  logic [2:0]   issue_lat   [2];
  logic         issue_ready [2];
  logic         res_valid   [2];
  logic [127:0] res_data    [2];

  logic [7:1]   st_valid [2];
  logic [7:1]   st_we    [2];
  logic [7:1]   st_done  [2];
  logic [6:0]   st_addr  [2][1:7];
  logic [2:0]   st_lat   [2][1:7];
  logic [127:0] st_data  [2][1:7];

  logic [7:1]   res_hit  [2];
  logic [7:1]   eff_done [2];
  logic [127:0] eff_data [2][1:7];
  logic         res_err  [2];

  logic         wb_valid [2];
  logic [6:0]   wb_addr  [2];
  logic [127:0] wb_data  [2];
  logic         wb_err   [2];

  logic [6:0]   fwd_addr [2];
  logic         fwd_hit  [2];
  logic [127:0] fwd_data [2];

  assign issue_valid[0] = bus.even_issue_valid;
  assign issue_valid[1] = bus.odd_issue_valid;
  assign issue_we[0]    = bus.even_issue_we;
  assign issue_we[1]    = bus.odd_issue_we;
  assign issue_addr[0]  = bus.even_issue_addr;
  assign issue_addr[1]  = bus.odd_issue_addr;
  assign issue_lat[0]   = bus.even_issue_lat;
  assign issue_lat[1]   = bus.odd_issue_lat;
  assign res_valid[0]   = bus.even_res_valid;
  assign res_valid[1]   = bus.odd_res_valid;
  assign res_data[0]    = bus.even_res_data;
  assign res_data[1]    = bus.odd_res_data;
  assign fwd_addr[0]    = bus.fwd_addr_a;
  assign fwd_addr[1]    = bus.fwd_addr_b;

  assign bus.even_issue_ready = issue_ready[0];
  assign bus.odd_issue_ready  = issue_ready[1];
  assign bus.reg_write_even   = wb_valid[0];
  assign bus.reg_write_odd    = wb_valid[1];
  assign bus.rt_addr_even     = wb_addr[0];
  assign bus.rt_addr_odd      = wb_addr[1];
  assign bus.rt_even          = wb_data[0];
  assign bus.rt_odd           = wb_data[1];
  assign bus.wb_err_even      = wb_err[0];
  assign bus.wb_err_odd       = wb_err[1];
  assign bus.fwd_hit_a        = fwd_hit[0];
  assign bus.fwd_hit_b        = fwd_hit[1];
  assign bus.fwd_data_a       = fwd_data[0];
  assign bus.fwd_data_b       = fwd_data[1];

  // Match this cycle's result strobe to the entry whose latency equals its stage.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      res_hit[p]  = '0;
      eff_done[p] = '0;
      for (int s = 1; s <= 7; s++) begin
        res_hit[p][s]  = res_valid[p] && st_valid[p][s] && (st_lat[p][s] == 3'(s));
        eff_done[p][s] = st_done[p][s] || res_hit[p][s];
        eff_data[p][s] = res_hit[p][s] ? res_data[p] : st_data[p][s];
      end
      res_err[p] = res_valid[p] && (res_hit[p] == '0);
    end
  end

  // Refuse illegal latencies and any issue whose completion slot is already taken.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      issue_ready[p] = (issue_lat[p] >= 3'd2);
      for (int s = 1; s <= 7; s++) begin
        if (st_valid[p][s] && ({1'b0, st_lat[p][s]} == ({1'b0, issue_lat[p]} + 4'(s))))
          issue_ready[p] = 1'b0;
      end
      if (!reset)
        issue_ready[p] = 1'b1;
    end
  end

  // Advance every entry one stage per cycle, folding in any captured result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < 2; p++) begin
        st_valid[p] <= '0;
        st_we[p]    <= '0;
        st_done[p]  <= '0;
        for (int s = 1; s <= 7; s++) begin
          st_addr[p][s] <= '0;
          st_lat[p][s]  <= '0;
          st_data[p][s] <= '0;
        end
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        st_valid[p][1] <= issue_valid[p] && issue_ready[p];
        st_we[p][1]    <= issue_valid[p] && issue_ready[p] && issue_we[p];
        st_done[p][1]  <= 1'b0;
        st_addr[p][1]  <= issue_addr[p];
        st_lat[p][1]   <= issue_lat[p];
        st_data[p][1]  <= '0;
        for (int s = 2; s <= 7; s++) begin
          st_valid[p][s] <= st_valid[p][s-1];
          st_we[p][s]    <= st_we[p][s-1];
          st_done[p][s]  <= eff_done[p][s-1];
          st_addr[p][s]  <= st_addr[p][s-1];
          st_lat[p][s]   <= st_lat[p][s-1];
          st_data[p][s]  <= eff_data[p][s-1];
        end
      end
    end
  end

  // Retire stage 7 into a one-cycle register-table write; bus is zero when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < 2; p++) begin
        wb_valid[p] <= 1'b0;
        wb_addr[p]  <= '0;
        wb_data[p]  <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (st_valid[p][7] && st_we[p][7] && eff_done[p][7]) begin
          wb_valid[p] <= 1'b1;
          wb_addr[p]  <= st_addr[p][7];
          wb_data[p]  <= eff_data[p][7];
        end else begin
          wb_valid[p] <= 1'b0;
          wb_addr[p]  <= '0;
          wb_data[p]  <= '0;
        end
      end
    end
  end

  // Sticky error: orphan result strobe, or a writing entry retiring without its result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < 2; p++)
        wb_err[p] <= 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (res_err[p] || (st_valid[p][7] && st_we[p][7] && !eff_done[p][7]))
          wb_err[p] <= 1'b1;
      end
    end
  end

  // Forwarding scans oldest to youngest so the youngest match (odd over even) overrides.
  always_comb begin
    for (int q = 0; q < 2; q++) begin
      fwd_hit[q]  = 1'b0;
      fwd_data[q] = '0;
      for (int p = 0; p < 2; p++) begin
        if (wb_valid[p] && (wb_addr[p] == fwd_addr[q])) begin
          fwd_hit[q]  = 1'b1;
          fwd_data[q] = wb_data[p];
        end
      end
      for (int s = 7; s >= 1; s--) begin
        for (int p = 0; p < 2; p++) begin
          if (st_valid[p][s] && st_we[p][s] && (st_addr[p][s] == fwd_addr[q])) begin
            fwd_hit[q]  = st_done[p][s];
            fwd_data[q] = st_done[p][s] ? st_data[p][s] : '0;
          end
        end
      end
    end
  end

endmodule
